// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver (data bits, parity, stop bits), optional 2-of-3 bit vote when UART_RX_MAJORITY_EN is defined
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Busy
);
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int IW = $clog2(DATA_BITS) + 1;
  localparam logic [CW-1:0] MID = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_D = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_S = IW'(STOP_BITS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, CLEANUP, BREAK_WAIT} state_t;
  state_t state, nxt;
  logic rx_meta, rx, bit_v, at_end, done, par_acc, fe_pend, par_err;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [DATA_BITS-1:0] word;
  generate
    if (PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
        DATA_BITS < 5 || DATA_BITS > 9 || CLKS_PER_BIT < 8) begin : g_bad_cfg
      $error("uart_rx_cfg: unsupported parameter combination");
    end
  endgenerate
`ifdef UART_RX_MAJORITY_EN
  logic rx_d;
  always_ff @(posedge i_Clock) rx_d <= i_Reset ? 1'b1 : rx;
  assign bit_v = (rx_d & rx) | (rx & rx_meta) | (rx_d & rx_meta);
`else
  assign bit_v = rx;
`endif
  assign at_end = (cnt == LAST);
  assign o_Busy = (state != IDLE);
  assign par_err = (PARITY == 1) ? ~par_acc : (PARITY == 2) ? par_acc : 1'b0;
  always_ff @(posedge i_Clock) state <= i_Reset ? IDLE : nxt;
  always_comb begin
    nxt = state;
    done = 1'b0;
    case (state)
      IDLE:       nxt = rx ? IDLE : START;
      START:      nxt = (cnt != MID) ? START : (bit_v ? IDLE : DATA);
      DATA:       nxt = (at_end && idx == LAST_D) ? ((PARITY != 0) ? PAR : STOP) : DATA;
      PAR:        nxt = at_end ? STOP : PAR;
      STOP: begin
        done = at_end && idx == LAST_S;
        nxt = !done ? STOP : ((fe_pend | ~bit_v) ? BREAK_WAIT : CLEANUP);
      end
      CLEANUP:    nxt = IDLE;
      BREAK_WAIT: nxt = rx ? IDLE : BREAK_WAIT;
      default:    nxt = IDLE;
    endcase
  end
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      rx_meta <= 1'b1;
      rx <= 1'b1;
      cnt <= '0;
      idx <= '0;
      word <= '0;
      par_acc <= 1'b0;
      fe_pend <= 1'b0;
      o_Rx_DV <= 1'b0;
      o_Rx_Byte <= '0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err <= 1'b0;
    end else begin
      rx_meta <= i_Rx_Serial;
      rx <= rx_meta;
      cnt <= ((state == START && cnt != MID) ||
              ((state == DATA || state == PAR || state == STOP) && !at_end)) ? cnt + CW'(1) : '0;
      idx <= (state == IDLE || (state == DATA && at_end && idx == LAST_D)) ? '0 :
             (at_end && (state == DATA || state == STOP)) ? idx + IW'(1) : idx;
      word <= (state == DATA && at_end) ? {bit_v, word[DATA_BITS-1:1]} : word;
      par_acc <= (state == IDLE) ? 1'b0 :
                 ((state == DATA || state == PAR) && at_end) ? par_acc ^ bit_v : par_acc;
      fe_pend <= (state == IDLE) ? 1'b0 : (state == STOP && at_end) ? fe_pend | ~bit_v : fe_pend;
      o_Rx_DV <= done;
      if (done) begin
        o_Rx_Byte <= word;
        o_Parity_Err <= par_err;
        o_Frame_Err <= fe_pend | ~bit_v;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed checks of uart_rx_cfg in 8N1, 7E1, 8N2 and 8E1 builds
module tb_uart_rx_cfg;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic [3:0] line, dv, pe, fe, busy;
  logic [3:0] dv_q = '0;
  logic [7:0] b0, b2, b3;
  logic [6:0] b1;
  logic [8:0] byt [4];
  logic [8:0] cap [4];
  logic cpe [4];
  logic cfe [4];
  int ndv [4];
  int nhi [4];
  int dv_cyc [4];
  int cyc = 0;
  int errs = 0;
  int checks = 0;
  int c0, n0;
  uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(line[0]), .o_Rx_DV(dv[0]),
    .o_Rx_Byte(b0), .o_Parity_Err(pe[0]), .o_Frame_Err(fe[0]), .o_Busy(busy[0]));
  uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u1 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(line[1]), .o_Rx_DV(dv[1]),
    .o_Rx_Byte(b1), .o_Parity_Err(pe[1]), .o_Frame_Err(fe[1]), .o_Busy(busy[1]));
  uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u2 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(line[2]), .o_Rx_DV(dv[2]),
    .o_Rx_Byte(b2), .o_Parity_Err(pe[2]), .o_Frame_Err(fe[2]), .o_Busy(busy[2]));
  uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u3 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(line[3]), .o_Rx_DV(dv[3]),
    .o_Rx_Byte(b3), .o_Parity_Err(pe[3]), .o_Frame_Err(fe[3]), .o_Busy(busy[3]));
  always_comb begin
    byt[0] = {1'b0, b0};
    byt[1] = {2'b0, b1};
    byt[2] = {1'b0, b2};
    byt[3] = {1'b0, b3};
  end
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    dv_q <= dv;
    for (int u = 0; u < 4; u++)
      if (dv[u]) begin
        nhi[u] <= nhi[u] + 1;
        if (!dv_q[u]) begin
          ndv[u] <= ndv[u] + 1;
          cap[u] <= byt[u];
          cpe[u] <= pe[u];
          cfe[u] <= fe[u];
          dv_cyc[u] <= cyc;
        end
      end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic hold(input int u, input logic v, input int n);
    line[u] = v;
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input int u, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) hold(u, bits[i], 16);
  endtask
  initial begin
    rst = 1'b1;
    line = '1;
    repeat (3) @(negedge clk);
    chk("rst_dv", dv, 0);
    chk("rst_busy", busy, 0);
    chk("rst_byte", b0, 0);
    chk("rst_flags", {pe, fe}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    send(0, {1'b1, 8'hA5, 1'b0}, 10);
    chk("b2b_byte1", cap[0], 9'hA5);
    chk("b2b_flags1", {cpe[0], cfe[0]}, 0);
    send(0, {1'b1, 8'h3C, 1'b0}, 10);
    chk("b2b_byte2", cap[0], 9'h3C);
    chk("b2b_flags2", {cpe[0], cfe[0]}, 0);
    chk("b2b_ndv", ndv[0], 2);
    chk("b2b_dv_width", nhi[0], 2);
    repeat (20) @(negedge clk);
    chk("b2b_idle", busy[0], 0);
    send(1, {1'b1, 1'b0, 7'h41, 1'b0}, 10);
    chk("par_ok_byte", cap[1], 9'h41);
    chk("par_ok_pe", cpe[1], 0);
    send(1, {1'b1, 1'b1, 7'h41, 1'b0}, 10);
    chk("par_bad_pe", cpe[1], 1);
    chk("par_bad_fe", cfe[1], 0);
    chk("par_bad_ndv", ndv[1], 2);
    chk("par_hold_pe", pe[1], 1);
    send(2, {1'b0, 1'b1, 8'h55, 1'b0}, 11);
    hold(2, 1'b0, 40 * 16);
    chk("brk_ndv", ndv[2], 1);
    chk("brk_fe", cfe[2], 1);
    chk("brk_byte", cap[2], 9'h55);
    chk("brk_busy", busy[2], 1);
    hold(2, 1'b1, 5);
    chk("brk_release", busy[2], 0);
    repeat (40) @(negedge clk);
    chk("brk_no_more_dv", ndv[2], 1);
    chk("brk_fe_held", fe[2], 1);
    n0 = ndv[0];
    hold(0, 1'b0, 3);
    chk("glitch_start", busy[0], 1);
    hold(0, 1'b1, 9);
    chk("glitch_idle", busy[0], 0);
    repeat (20) @(negedge clk);
    chk("glitch_no_dv", ndv[0], n0);
    c0 = cyc;
    send(3, {1'b1, 1'b0, 8'hA5, 1'b0}, 11);
    chk("lat_window", (dv_cyc[3] - c0 >= 170) && (dv_cyc[3] - c0 <= 172), 1);
    chk("lat_byte", cap[3], 9'hA5);
    chk("lat_pe", cpe[3], 0);
    send(0, 16'b11110, 5);
    hold(0, 1'b1, 8);
    chk("rstmid_busy", busy[0], 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_outs", {dv[0], pe[0], fe[0], busy[0]}, 0);
    chk("rstmid_byte", b0, 0);
    rst = 1'b0;
    hold(0, 1'b1, 4 * 16);
    chk("rstmid_no_dv", ndv[0], n0);
    send(0, {1'b1, 8'h5A, 1'b0}, 10);
    chk("rstmid_next_byte", cap[0], 9'h5A);
    chk("rstmid_next_ndv", ndv[0], n0 + 1);
`ifdef UART_RX_MAJORITY_EN
    send(0, 16'h0000, 4);
    hold(0, 1'b0, 8);
    hold(0, 1'b1, 1);
    hold(0, 1'b0, 7);
    send(0, 16'b10000, 5);
    chk("maj_byte", cap[0], 9'h00);
    chk("maj_ndv", ndv[0], n0 + 2);
`endif
    repeat (20) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver: start bit, DATA_BITS data bits LSB first, optional odd/even parity, 1 or 2 stop bits.
Flags parity and framing errors alongside each received word.
Blocks re-triggering during a line break.
Sits behind the board serial input pin and feeds the command/byte parser; supersedes the fixed 8N1 receiver.

Parameters:
CLKS_PER_BIT, 87, i_Clock cycles per bit (Fclk/baud); legal >= 8.
DATA_BITS, 8, data bits per frame; legal 5..9.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, stop bits checked; legal 1 or 2.

Ports:
i_Clock  in  1  system clock, single domain.
i_Reset  in  1  synchronous, active-high reset.
i_Rx_Serial  in  1  asynchronous serial line, idle high.
o_Rx_DV  out  1  one-cycle pulse: word and flags valid.
o_Rx_Byte  out  DATA_BITS  received word, bit 0 = first data bit on the line.
o_Parity_Err  out  1  parity mismatch on last word; 0 when PARITY = 0.
o_Frame_Err  out  1  a stop bit sampled low on last word.
o_Busy  out  1  high in any state other than IDLE.

Behaviour:
- Synchroniser: 2-flop chain on i_Rx_Serial; both flops reset to 1. All decisions use the second flop ("rx").
- Bit-centre counter: width $clog2(CLKS_PER_BIT)+1. Bit index: width $clog2(DATA_BITS)+1.
- Reset: on i_Reset high at a clock edge the block returns to IDLE from any state, including mid-frame, and clears:
  - o_Rx_DV, o_Rx_Byte, o_Parity_Err, o_Frame_Err, o_Busy -> 0
  - counters -> 0
  - the partial word is discarded.
- States:
  - IDLE: counter=0, index=0. rx==0 -> START.
  - START: counter increments until it equals (CLKS_PER_BIT-1)/2.
    - rx still 0 at that point -> counter=0, go to DATA.
    - rx is 1 -> IDLE (glitch rejected, no DV, no flags).
  - DATA: wait CLKS_PER_BIT-1 cycles (counter 0..CLKS_PER_BIT-1), then sample rx into the shift position given by index.
    - After DATA_BITS samples: go to PARITY if PARITY != 0, else STOP.
  - PARITY: same timing, sample rx.
    - Parity error when XOR(data bits, parity bit) is 0 for odd, or 1 for even.
  - STOP: same timing per stop bit, sample rx; any stop sample of 0 sets the pending framing error.
    - After STOP_BITS samples, at the sample cycle of the last stop bit, register outputs:
      - o_Rx_Byte <= word
      - o_Parity_Err, o_Frame_Err <= pending flags
      - o_Rx_DV <= 1 next cycle
    - Next state: CLEANUP if no framing error, else BREAK_WAIT.
  - CLEANUP: o_Rx_DV high this cycle only; -> IDLE.
  - BREAK_WAIT: o_Rx_DV high on entry cycle only; remain until rx==1, then -> IDLE. A held-low line yields exactly one DV with o_Frame_Err=1.
- Output timing:
  - o_Rx_Byte and the error flags hold their values until the next DV.
  - DV always coincides with valid flags.
- Latency: DV asserts 2 (sync) + 1 + (CLKS_PER_BIT-1)/2 + (DATA_BITS + P + STOP_BITS)*CLKS_PER_BIT + 1 cycles after the line's falling edge, where P = (PARITY != 0). The bench checks the ±1 cycle window.
- Back-to-back frames: a start edge arriving during CLEANUP is detected in IDLE the next cycle. The frame is received without loss provided it arrives >= 1 cycle after DV.
- Unsupported parameter values (PARITY > 2, STOP_BITS not 1 or 2, DATA_BITS out of range): elaboration-time error via generate-if with a $error call.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: each bit (start, data, parity, stop) is decided by 2-of-3 majority of rx at counter values centre-1, centre, centre+1. The start check uses the same vote; single-cycle glitches within the window are rejected.
- Undefined: single sample at the centre cycle, as described above.
- Latency is identical in both builds: the decision is still taken at counter == CLKS_PER_BIT-1 for data/parity/stop bits.

Test Plan:
- Basic: CLKS_PER_BIT=16, 8N1, send 0xA5 then 0x3C back-to-back -> two DV pulses, o_Rx_Byte = 0xA5 then 0x3C, both flags 0, each DV exactly 1 cycle.
- Parity: DATA_BITS=7, PARITY=2 (even), send 0x41 with parity 0 -> byte 0x41, o_Parity_Err=0. Same word with parity 1 -> o_Parity_Err=1, DV still asserted.
- Framing/break: 8N2, second stop bit driven low; then line held low 40 bit times -> exactly one DV with o_Frame_Err=1, o_Busy high until the line returns high, no further DV.
- Glitch: 3-cycle low pulse on an idle line (CLKS_PER_BIT=16) -> no DV, back in IDLE within 12 cycles. With UART_RX_MAJORITY_EN, a 1-cycle inverted glitch at centre of data bit 3 of 0x00 -> byte 0x00.
- Reset mid-frame: assert i_Reset for 1 cycle during data bit 4 of 0xFF -> all outputs 0 next cycle, no DV for that frame. A following clean 0x5A is received correctly.
- Latency: 8E1, CLKS_PER_BIT=16 -> DV at 2+1+7+(8+1+1)*16+1 = 171 ±1 cycles after the falling edge.
